// File: rtl/mem_bus_arbiter.sv
// Arbitrates the memory bus between icache and dcache and steers returned tags to their owner.
// Grant and tag steering are combinational; owner table and counters update on the next edge.
module mem_bus_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [1:0]                   icache2arb_command,
  input  logic [XLEN-1:0]              icache2arb_addr,
  input  logic [1:0]                   dcache2arb_command,
  input  logic [XLEN-1:0]              dcache2arb_addr,
  input  logic [63:0]                  dcache2arb_data,
  input  logic [$clog2(NUM_TAGS)-1:0]  mem2arb_response,
  input  logic [63:0]                  mem2arb_data,
  input  logic [$clog2(NUM_TAGS)-1:0]  mem2arb_tag,
  output logic [1:0]                   arb2mem_command,
  output logic [XLEN-1:0]              arb2mem_addr,
  output logic [63:0]                  arb2mem_data,
  output logic [$clog2(NUM_TAGS)-1:0]  arb2icache_response,
  output logic [$clog2(NUM_TAGS)-1:0]  arb2dcache_response,
  output logic [$clog2(NUM_TAGS)-1:0]  arb2icache_tag,
  output logic [$clog2(NUM_TAGS)-1:0]  arb2dcache_tag,
  output logic [63:0]                  arb2cache_data,
  output logic [$clog2(NUM_TAGS):0]    icache_outstanding,
  output logic                         tag_conflict
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int OUT_W = TAG_W + 1;
  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0]          starve_q, starve_d;
  logic [NUM_TAGS-1:0] valid_q, valid_d;
  logic [NUM_TAGS-1:0] owner_q, owner_d;
  logic [OUT_W-1:0]    outstanding_q, outstanding_d;
  logic                conflict_q, conflict_d;

  logic icache_req, dcache_req, force_i, icache_gnt, dcache_gnt;
  logic alloc, alloc_i, done, done_i, done_owner;

  always_comb begin
    icache_req = icache2arb_command != BUS_NONE;
    dcache_req = dcache2arb_command != BUS_NONE;
    force_i    = icache_req && (starve_q == STARVE_MAX);
    dcache_gnt = !reset && dcache_req && !force_i;
    icache_gnt = !reset && icache_req && !dcache_gnt;

    arb2mem_command = BUS_NONE;
    arb2mem_addr    = '0;
    arb2mem_data    = '0;
    if (dcache_gnt) begin
      arb2mem_command = dcache2arb_command;
      arb2mem_addr    = dcache2arb_addr;
      if (dcache2arb_command == BUS_STORE) arb2mem_data = dcache2arb_data;
    end else if (icache_gnt) begin
      arb2mem_command = icache2arb_command;
      arb2mem_addr    = icache2arb_addr;
    end

    arb2icache_response = icache_gnt ? mem2arb_response : '0;
    arb2dcache_response = dcache_gnt ? mem2arb_response : '0;
    arb2cache_data      = mem2arb_data;

    // A granted load only occupies a tag once memory actually accepts it.
    alloc   = (mem2arb_response != '0) && (arb2mem_command == BUS_LOAD);
    alloc_i = alloc && icache_gnt;

    done       = !reset && (mem2arb_tag != '0) && valid_q[mem2arb_tag];
    done_owner = owner_q[mem2arb_tag];
    done_i     = done && !done_owner;
    arb2icache_tag = done_i ? mem2arb_tag : '0;
    arb2dcache_tag = (done && done_owner) ? mem2arb_tag : '0;

    // Completion is applied before allocation so a recycled tag ends valid with its new owner.
    valid_d = valid_q;
    owner_d = owner_q;
    if (done) valid_d[mem2arb_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2arb_response] = 1'b1;
      owner_d[mem2arb_response] = dcache_gnt;
    end
    conflict_d = conflict_q ||
                 (alloc && valid_q[mem2arb_response] &&
                  !(done && (mem2arb_tag == mem2arb_response)));

    outstanding_d = outstanding_q;
    if (alloc_i && !done_i) outstanding_d = outstanding_q + OUT_W'(1);
    else if (!alloc_i && done_i) outstanding_d = outstanding_q - OUT_W'(1);

    starve_d = starve_q;
    if (!icache_req || icache_gnt) starve_d = '0;
    else if (dcache_gnt && (starve_q < STARVE_MAX)) starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q      <= '0;
      valid_q       <= '0;
      owner_q       <= '0;
      outstanding_q <= '0;
      conflict_q    <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      conflict_q    <= conflict_d;
    end
  end

  assign icache_outstanding = outstanding_q;
  assign tag_conflict       = conflict_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant priority, starvation escape, tag ownership and reset.
module tb_mem_bus_arbiter;

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache2arb_command, dcache2arb_command;
  logic [31:0] icache2arb_addr, dcache2arb_addr;
  logic [63:0] dcache2arb_data, mem2arb_data;
  logic [3:0]  mem2arb_response, mem2arb_tag;
  logic [1:0]  arb2mem_command;
  logic [31:0] arb2mem_addr;
  logic [63:0] arb2mem_data, arb2cache_data;
  logic [3:0]  arb2icache_response, arb2dcache_response, arb2icache_tag, arb2dcache_tag;
  logic [4:0]  icache_outstanding;
  logic        tag_conflict;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .icache2arb_command(icache2arb_command), .icache2arb_addr(icache2arb_addr),
    .dcache2arb_command(dcache2arb_command), .dcache2arb_addr(dcache2arb_addr),
    .dcache2arb_data(dcache2arb_data),
    .mem2arb_response(mem2arb_response), .mem2arb_data(mem2arb_data), .mem2arb_tag(mem2arb_tag),
    .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr), .arb2mem_data(arb2mem_data),
    .arb2icache_response(arb2icache_response), .arb2dcache_response(arb2dcache_response),
    .arb2icache_tag(arb2icache_tag), .arb2dcache_tag(arb2dcache_tag),
    .arb2cache_data(arb2cache_data),
    .icache_outstanding(icache_outstanding), .tag_conflict(tag_conflict)
  );

  always #5 clock = ~clock;

  task automatic idle();
    icache2arb_command = BUS_NONE; icache2arb_addr = '0;
    dcache2arb_command = BUS_NONE; dcache2arb_addr = '0; dcache2arb_data = '0;
    mem2arb_response = '0; mem2arb_data = '0; mem2arb_tag = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h40;
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h80;
    mem2arb_response = 4'd6; mem2arb_tag = 4'd6;
    #1;
    total++; if (arb2mem_command !== BUS_NONE) begin bad++; $display("FAIL rst_cmd got=%0d exp=%0d", arb2mem_command, BUS_NONE); end
    total++; if (arb2icache_response !== 4'd0 || arb2dcache_response !== 4'd0) begin bad++; $display("FAIL rst_resp got i=%0d d=%0d exp 0/0", arb2icache_response, arb2dcache_response); end
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL rst_tag got i=%0d d=%0d exp 0/0", arb2icache_tag, arb2dcache_tag); end
    total++; if (icache_outstanding !== 5'd0 || tag_conflict !== 1'b0) begin bad++; $display("FAIL rst_state got out=%0d conf=%0b exp 0/0", icache_outstanding, tag_conflict); end
    tick();
    reset = 1'b0; idle();
    tick();
  endtask

  task automatic test_icache_only();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h100; mem2arb_response = 4'd3;
    #1;
    total++; if (arb2mem_command !== BUS_LOAD || arb2mem_addr !== 32'h100) begin bad++; $display("FAIL t1_cmd got cmd=%0d addr=%h exp 1/100", arb2mem_command, arb2mem_addr); end
    total++; if (arb2icache_response !== 4'd3 || arb2dcache_response !== 4'd0) begin bad++; $display("FAIL t1_resp got i=%0d d=%0d exp 3/0", arb2icache_response, arb2dcache_response); end
    tick(); idle(); #1;
    total++; if (icache_outstanding !== 5'd1) begin bad++; $display("FAIL t1_out got=%0d exp=1", icache_outstanding); end
    tick(); tick();
    mem2arb_tag = 4'd3; mem2arb_data = 64'h1234_5678_9abc_def0; #1;
    total++; if (arb2icache_tag !== 4'd3 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL t1_tag got i=%0d d=%0d exp 3/0", arb2icache_tag, arb2dcache_tag); end
    total++; if (arb2cache_data !== 64'h1234_5678_9abc_def0) begin bad++; $display("FAIL t1_data got=%h exp=123456789abcdef0", arb2cache_data); end
    tick(); idle(); #1;
    total++; if (icache_outstanding !== 5'd0) begin bad++; $display("FAIL t1_out_done got=%0d exp=0", icache_outstanding); end
    tick();
  endtask

  task automatic test_both_load();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h200;
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h300; mem2arb_response = 4'd5;
    #1;
    total++; if (arb2mem_addr !== 32'h300) begin bad++; $display("FAIL t2_addr got=%h exp=300", arb2mem_addr); end
    total++; if (arb2dcache_response !== 4'd5 || arb2icache_response !== 4'd0) begin bad++; $display("FAIL t2_resp got d=%0d i=%0d exp 5/0", arb2dcache_response, arb2icache_response); end
    tick(); idle(); tick();
    mem2arb_tag = 4'd5; #1;
    total++; if (arb2dcache_tag !== 4'd5 || arb2icache_tag !== 4'd0) begin bad++; $display("FAIL t2_tag got d=%0d i=%0d exp 5/0", arb2dcache_tag, arb2icache_tag); end
    total++; if (icache_outstanding !== 5'd0) begin bad++; $display("FAIL t2_out got=%0d exp=0", icache_outstanding); end
    tick(); idle(); tick();
  endtask

  // Every fifth cycle of continuous contention goes to the icache, then the count restarts.
  task automatic test_starvation();
    logic [31:0] exp_addr;
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h600;
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h500;
    for (int c = 1; c <= 10; c++) begin
      exp_addr = (c % 5 == 0) ? 32'h600 : 32'h500;
      #1;
      total++; if (arb2mem_addr !== exp_addr) begin bad++; $display("FAIL t3_cycle%0d got=%h exp=%h", c, arb2mem_addr, exp_addr); end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_store();
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h480; dcache2arb_data = 64'hBEEF; #1;
    total++; if (arb2mem_data !== 64'd0) begin bad++; $display("FAIL t4_load_data got=%h exp=0", arb2mem_data); end
    tick();
    dcache2arb_command = BUS_STORE; dcache2arb_addr = 32'h400; dcache2arb_data = 64'hDEAD;
    mem2arb_response = 4'd2; #1;
    total++; if (arb2mem_command !== BUS_STORE || arb2mem_data !== 64'hDEAD) begin bad++; $display("FAIL t4_store got cmd=%0d data=%h exp 2/dead", arb2mem_command, arb2mem_data); end
    total++; if (arb2dcache_response !== 4'd2) begin bad++; $display("FAIL t4_resp got=%0d exp=2", arb2dcache_response); end
    tick(); idle(); tick();
    mem2arb_tag = 4'd2; #1;
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL t4_tag got i=%0d d=%0d exp 0/0", arb2icache_tag, arb2dcache_tag); end
    tick(); idle(); tick();
  endtask

  task automatic test_same_cycle_reuse();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h700; mem2arb_response = 4'd7;
    tick(); idle();
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h780; mem2arb_response = 4'd7; mem2arb_tag = 4'd7; #1;
    total++; if (arb2icache_tag !== 4'd7 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL t5_tag_old got i=%0d d=%0d exp 7/0", arb2icache_tag, arb2dcache_tag); end
    total++; if (arb2dcache_response !== 4'd7) begin bad++; $display("FAIL t5_resp got=%0d exp=7", arb2dcache_response); end
    tick(); idle(); #1;
    total++; if (icache_outstanding !== 5'd0 || tag_conflict !== 1'b0) begin bad++; $display("FAIL t5_state got out=%0d conf=%0b exp 0/0", icache_outstanding, tag_conflict); end
    mem2arb_tag = 4'd7; #1;
    total++; if (arb2dcache_tag !== 4'd7 || arb2icache_tag !== 4'd0) begin bad++; $display("FAIL t5_tag_new got d=%0d i=%0d exp 7/0", arb2dcache_tag, arb2icache_tag); end
    tick(); idle(); tick();
  endtask

  task automatic test_conflict();
    dcache2arb_command = BUS_LOAD; dcache2arb_addr = 32'h900; mem2arb_response = 4'd9;
    tick(); idle();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'h940; mem2arb_response = 4'd9; #1;
    total++; if (tag_conflict !== 1'b0) begin bad++; $display("FAIL tc_before got=%0b exp=0", tag_conflict); end
    tick(); idle(); #1;
    total++; if (tag_conflict !== 1'b1 || icache_outstanding !== 5'd1) begin bad++; $display("FAIL tc_set got conf=%0b out=%0d exp 1/1", tag_conflict, icache_outstanding); end
    mem2arb_tag = 4'd9; #1;
    total++; if (arb2icache_tag !== 4'd9 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL tc_tag got i=%0d d=%0d exp 9/0", arb2icache_tag, arb2dcache_tag); end
    tick(); idle(); #1;
    total++; if (tag_conflict !== 1'b1 || icache_outstanding !== 5'd0) begin bad++; $display("FAIL tc_sticky got conf=%0b out=%0d exp 1/0", tag_conflict, icache_outstanding); end
    tick();
  endtask

  task automatic test_reset_drop();
    icache2arb_command = BUS_LOAD; icache2arb_addr = 32'hA00; mem2arb_response = 4'd1;
    tick();
    icache2arb_addr = 32'hA40; mem2arb_response = 4'd2;
    tick(); idle(); #1;
    total++; if (icache_outstanding !== 5'd2) begin bad++; $display("FAIL t6_out got=%0d exp=2", icache_outstanding); end
    reset = 1'b1; icache2arb_command = BUS_LOAD; mem2arb_response = 4'd4; mem2arb_tag = 4'd2; #1;
    total++; if (arb2mem_command !== BUS_NONE || arb2icache_response !== 4'd0 || arb2icache_tag !== 4'd0) begin bad++; $display("FAIL t6_in_reset got cmd=%0d resp=%0d tag=%0d exp 0/0/0", arb2mem_command, arb2icache_response, arb2icache_tag); end
    tick();
    reset = 1'b0; idle(); #1;
    total++; if (icache_outstanding !== 5'd0 || tag_conflict !== 1'b0) begin bad++; $display("FAIL t6_cleared got out=%0d conf=%0b exp 0/0", icache_outstanding, tag_conflict); end
    mem2arb_tag = 4'd1; #1;
    total++; if (arb2icache_tag !== 4'd0 || arb2dcache_tag !== 4'd0) begin bad++; $display("FAIL t6_drop got i=%0d d=%0d exp 0/0", arb2icache_tag, arb2dcache_tag); end
    tick(); idle(); tick();
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_both_load();
    test_starvation();
    test_store();
    test_same_cycle_reuse();
    test_conflict();
    test_reset_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
